// File: rtl/pipe_dbg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_dbg_pkg
// Description : Shared types and widths for the pipeline debug controller:
//               command opcodes, controller states, register-select and PC
//               widths.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_dbg_pkg;

    localparam int REG_SEL_W = 5;
    localparam int PC_W      = 32;

    typedef enum logic [2:0] {
        OP_RUN      = 3'd0,
        OP_HALT     = 3'd1,
        OP_STEP     = 3'd2,
        OP_SET_BP   = 3'd3,
        OP_CLR_BP   = 3'd4,
        OP_READ_REG = 3'd5,
        OP_READ_CYC = 3'd6
    } dbg_op_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_STEP   = 2'd2,
        ST_RDREG  = 2'd3
    } dbg_state_e;

endpackage
`default_nettype wire

// File: rtl/pipe_dbg_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_dbg_if
// Description : Debug command / response channel plus the CPU-side signals
//               (retire, pipeline enable, register read port) seen by the
//               debug controller.  The master side is the host together with
//               the core; the slave side is the controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_dbg_if;
    import pipe_dbg_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [2:0]           cmd_op;
    logic [2:0]           cmd_idx;
    logic [31:0]          cmd_arg;
    logic                 wb_valid;
    logic [PC_W-1:0]      wb_pc;
    logic                 pipe_en;
    logic                 halted;
    logic [REG_SEL_W-1:0] reg_sel;
    logic [31:0]          reg_data;
    logic                 rsp_valid;
    logic                 rsp_err;
    logic [31:0]          rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_idx, cmd_arg, wb_valid, wb_pc, reg_data,
        input  cmd_ready, pipe_en, halted, reg_sel, rsp_valid, rsp_err, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_idx, cmd_arg, wb_valid, wb_pc, reg_data,
        output cmd_ready, pipe_en, halted, reg_sel, rsp_valid, rsp_err, rsp_data
    );

endinterface
`default_nettype wire

// File: rtl/pipe_dbg_bp_match.sv
`default_nettype none
// ============================================================================
// Module      : pipe_dbg_bp_match
// Description : PC breakpoint slots with a parallel comparator against the
//               retiring PC.  The hit flag is already qualified by wb_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_dbg_bp_match
    import pipe_dbg_pkg::*;
#(
    parameter int NUM_BP = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic            wr_set,
    input  logic [2:0]      wr_idx,
    input  logic [PC_W-1:0] wr_pc,
    input  logic            wb_valid,
    input  logic [PC_W-1:0] wb_pc,
    output logic            hit
);

    logic [NUM_BP-1:0] w_match;

    generate
        for (genvar i = 0; i < NUM_BP; i++) begin : g_slot
            logic            r_en;
            logic [PC_W-1:0] r_pc;

            // Slot i: a set loads the PC and arms the slot, a clear disarms it.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_en <= 1'b0;
                    r_pc <= '0;
                end else if (wr_en && (wr_idx == 3'(i))) begin
                    r_en <= wr_set;
                    if (wr_set) begin
                        r_pc <= wr_pc;
                    end
                end
            end

            assign w_match[i] = r_en && (r_pc == wb_pc);
        end
    endgenerate

    assign hit = wb_valid && (|w_match);

endmodule
`default_nettype wire

// File: rtl/pipe_dbg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_dbg_ctrl
// Description : Run/halt/step debug controller for the 5-stage pipeline.
//               Drives the global pipeline enable, halts on PC breakpoints
//               seen at writeback, single-steps N retired instructions and
//               reads the register file through the core's debug port.
//               Optional feature macro: PIPE_DBG_CYCLE_CNT_EN adds a 32-bit
//               enabled-cycle counter readable with READ_CYC.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_dbg_ctrl
    import pipe_dbg_pkg::*;
#(
    parameter int NUM_BP = 2,
    parameter int STEP_W = 16
) (
    input  logic      clk,
    input  logic      rst,
    pipe_dbg_if.slave dbg
);

    dbg_state_e           r_state, w_state_nxt;
    logic [STEP_W-1:0]    r_step_cnt, w_step_nxt;
    logic [REG_SEL_W-1:0] r_reg_sel, w_reg_sel_nxt;
    logic                 r_rsp_valid, w_rsp_valid_nxt;
    logic                 r_rsp_err, w_rsp_err_nxt;
    logic [31:0]          r_rsp_data, w_rsp_data_nxt;

    logic                 w_cmd_ready;
    logic                 w_accept;
    logic                 w_pipe_en;
    logic                 w_idx_ok;
    logic                 w_bp_wr;
    logic                 w_bp_set;
    logic                 w_bp_hit;
    logic [STEP_W-1:0]    w_step_arg;

    assign w_cmd_ready = (r_state == ST_RUN) || (r_state == ST_HALTED);
    assign w_accept    = dbg.cmd_valid && w_cmd_ready;
    assign w_pipe_en   = (r_state == ST_RUN) || (r_state == ST_STEP);
    // Widen by one bit so NUM_BP = 8 still compares correctly.
    assign w_idx_ok    = ({1'b0, dbg.cmd_idx} < 4'(NUM_BP));
    assign w_step_arg  = dbg.cmd_arg[STEP_W-1:0];

    pipe_dbg_bp_match #(
        .NUM_BP (NUM_BP)
    ) u_bp_match (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (w_bp_wr),
        .wr_set   (w_bp_set),
        .wr_idx   (dbg.cmd_idx),
        .wr_pc    (dbg.cmd_arg),
        .wb_valid (dbg.wb_valid),
        .wb_pc    (dbg.wb_pc),
        .hit      (w_bp_hit)
    );

`ifdef PIPE_DBG_CYCLE_CNT_EN
    logic [31:0] r_cyc_cnt;

    // Count cycles in which the pipeline was enabled; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc_cnt <= '0;
        end else if (w_pipe_en) begin
            r_cyc_cnt <= r_cyc_cnt + 32'd1;
        end
    end
`endif

    // Next state, command decode and response generation.
    always_comb begin
        w_state_nxt     = r_state;
        w_step_nxt      = r_step_cnt;
        w_reg_sel_nxt   = r_reg_sel;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_data_nxt  = '0;
        w_bp_wr         = 1'b0;
        w_bp_set        = 1'b0;

        case (r_state)
            ST_RUN, ST_HALTED: begin
                if (w_accept) begin
                    w_rsp_valid_nxt = 1'b1;
                    case (dbg.cmd_op)
                        OP_RUN:  w_state_nxt = ST_RUN;
                        OP_HALT: w_state_nxt = ST_HALTED;
                        OP_STEP: begin
                            if (r_state == ST_RUN) begin
                                w_rsp_err_nxt = 1'b1;
                            end else begin
                                // Response is deferred until the last retire.
                                w_rsp_valid_nxt = 1'b0;
                                w_state_nxt     = ST_STEP;
                                w_step_nxt      = (w_step_arg == '0) ? STEP_W'(1) : w_step_arg;
                            end
                        end
                        OP_SET_BP, OP_CLR_BP: begin
                            if (w_idx_ok) begin
                                w_bp_wr  = 1'b1;
                                w_bp_set = (dbg.cmd_op == OP_SET_BP);
                            end else begin
                                w_rsp_err_nxt = 1'b1;
                            end
                        end
                        OP_READ_REG: begin
                            if (r_state == ST_RUN) begin
                                w_rsp_err_nxt = 1'b1;
                            end else begin
                                // Register data is captured one edge later.
                                w_rsp_valid_nxt = 1'b0;
                                w_state_nxt     = ST_RDREG;
                                w_reg_sel_nxt   = dbg.cmd_arg[REG_SEL_W-1:0];
                            end
                        end
                        OP_READ_CYC: begin
`ifdef PIPE_DBG_CYCLE_CNT_EN
                            w_rsp_data_nxt = r_cyc_cnt;
`else
                            w_rsp_err_nxt  = 1'b1;
`endif
                        end
                        default: w_rsp_err_nxt = 1'b1;
                    endcase
                end
                // A breakpoint hit wins over any state change the command asked for.
                if ((r_state == ST_RUN) && w_bp_hit) begin
                    w_state_nxt = ST_HALTED;
                end
            end
            ST_STEP: begin
                if (dbg.wb_valid) begin
                    w_step_nxt = r_step_cnt - STEP_W'(1);
                    if (r_step_cnt == STEP_W'(1)) begin
                        w_state_nxt     = ST_HALTED;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_data_nxt  = dbg.wb_pc;
                    end
                end
            end
            ST_RDREG: begin
                w_state_nxt     = ST_HALTED;
                w_rsp_valid_nxt = 1'b1;
                w_rsp_data_nxt  = dbg.reg_data;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // State, step counter, register select and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_step_cnt  <= '0;
            r_reg_sel   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_step_cnt  <= w_step_nxt;
            r_reg_sel   <= w_reg_sel_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
        end
    end

    assign dbg.cmd_ready = w_cmd_ready;
    assign dbg.pipe_en   = w_pipe_en;
    assign dbg.halted    = (r_state == ST_HALTED) || (r_state == ST_RDREG);
    assign dbg.reg_sel   = r_reg_sel;
    assign dbg.rsp_valid = r_rsp_valid;
    assign dbg.rsp_err   = r_rsp_err;
    assign dbg.rsp_data  = r_rsp_data;

endmodule
`default_nettype wire
